gpr_file_mp: RTL and testbench

- Parametrised multi-port general-purpose register file, the successor to the single-write/dual-read WB-stage register file.
- Sits between ID (read ports, combinational) and WB (write ports, sequential).
- Adds configurable width, depth and port counts, plus deterministic write-port priority.
- Adds a post-reset clear sweep FSM and an optional per-register busy scoreboard for hazard detection in ID.

---
 rtl/gpr_file_mp.sv | 143 ++++++++++++++
 tb/tb_gpr_file_mp.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpr_file_mp.sv
//------------------------------------------------------------------------------
// Module      : gpr_file_mp
// Description : Multi-port GPR file with post-reset clear sweep and write-through
//               bypass. Define GPR_SCOREBOARD_EN for the per-register busy bits.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module gpr_file_mp #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2,
   parameter int NUM_WR = 1
) (
   input  logic                       clk_i,
   input  logic                       n_rst_i,
   input  logic [NUM_WR-1:0]          rd_we_i,
   input  logic [NUM_WR*ADDR_W-1:0]   rd_wa_i,
   input  logic [NUM_WR*DATA_W-1:0]   rd_wd_i,
   input  logic [NUM_RD-1:0]          rs_re_i,
   input  logic [NUM_RD*ADDR_W-1:0]   rs_ra_i,
   output logic [NUM_RD*DATA_W-1:0]   rs_rd_o,
   output logic                       init_done_o,
   input  logic                       iss_we_i,
   input  logic [ADDR_W-1:0]          iss_wa_i,
   output logic [NUM_RD-1:0]          rs_busy_o
);

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam logic [ADDR_W-1:0] c_cnt_first = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] c_cnt_last  = ADDR_W'(DEPTH - 1);

   state_t              r_state;
   logic [ADDR_W-1:0]   r_cnt;
   logic                r_init_done;
   logic [DATA_W-1:0]   r_regs [DEPTH];
   logic                w_run;

   // Sweep FSM: entry 0 is never stored, so the sweep starts at 1.
   always_ff @(posedge clk_i or negedge n_rst_i) begin
      if (!n_rst_i) begin
         r_state     <= ST_INIT;
         r_cnt       <= c_cnt_first;
         r_init_done <= 1'b0;
      end else begin
         case (r_state)
            ST_INIT: begin
               if (r_cnt == c_cnt_last) begin
                  r_state     <= ST_RUN;
                  r_init_done <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_RUN: begin
               r_state <= ST_RUN;
            end
            default: begin
               r_state <= ST_INIT;
            end
         endcase
      end
   end

   assign init_done_o = r_init_done;
   assign w_run       = n_rst_i && (r_state == ST_RUN);

   // Later ports overwrite earlier ones, giving the highest index priority.
   always_ff @(posedge clk_i) begin
      if (r_state == ST_INIT) begin
         r_regs[r_cnt] <= '0;
      end else begin
         for (int k = 0; k < NUM_WR; k++) begin
            if (rd_we_i[k] && (rd_wa_i[k*ADDR_W +: ADDR_W] != '0)) begin
               r_regs[rd_wa_i[k*ADDR_W +: ADDR_W]] <= rd_wd_i[k*DATA_W +: DATA_W];
            end
         end
      end
   end

`ifdef GPR_SCOREBOARD_EN
   logic [DEPTH-1:0] r_busy;

   // Issue is applied after writeback so a same-cycle collision leaves the bit set.
   always_ff @(posedge clk_i or negedge n_rst_i) begin
      if (!n_rst_i) begin
         r_busy <= '0;
      end else if (r_state == ST_RUN) begin
         for (int k = 0; k < NUM_WR; k++) begin
            if (rd_we_i[k]) begin
               r_busy[rd_wa_i[k*ADDR_W +: ADDR_W]] <= 1'b0;
            end
         end
         if (iss_we_i && (iss_wa_i != '0)) begin
            r_busy[iss_wa_i] <= 1'b1;
         end
      end
   end
`else
   logic w_unused_iss;
   assign w_unused_iss = ^{iss_we_i, iss_wa_i};
`endif

   generate
      for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
         logic [ADDR_W-1:0] w_ra;
         logic [DATA_W-1:0] w_byp;
         logic              w_hit;
         logic              w_valid;

         assign w_ra    = rs_ra_i[j*ADDR_W +: ADDR_W];
         assign w_valid = w_run && (w_ra != '0) && rs_re_i[j];

         always_comb begin
            w_hit = 1'b0;
            w_byp = '0;
            for (int k = 0; k < NUM_WR; k++) begin
               if (rd_we_i[k] && (rd_wa_i[k*ADDR_W +: ADDR_W] == w_ra)) begin
                  w_hit = 1'b1;
                  w_byp = rd_wd_i[k*DATA_W +: DATA_W];
               end
            end
         end

         assign rs_rd_o[j*DATA_W +: DATA_W] = !w_valid ? '0 :
                                             w_hit    ? w_byp : r_regs[w_ra];

`ifdef GPR_SCOREBOARD_EN
         assign rs_busy_o[j] = w_valid && r_busy[w_ra] && !w_hit;
`else
         assign rs_busy_o[j] = 1'b0;
`endif
      end
   endgenerate

endmodule

`default_nettype wire

// File: tb/tb_gpr_file_mp.sv
//------------------------------------------------------------------------------
// Module      : tb_gpr_file_mp
// Description : Directed bench for gpr_file_mp (NUM_WR=2, NUM_RD=2, DEPTH=32).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_gpr_file_mp;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 32;
   localparam int ADDR_W = 5;
   localparam int NUM_RD = 2;
   localparam int NUM_WR = 2;

   logic                     clk_i = 1'b0;
   logic                     n_rst_i;
   logic [NUM_WR-1:0]        rd_we_i;
   logic [NUM_WR*ADDR_W-1:0] rd_wa_i;
   logic [NUM_WR*DATA_W-1:0] rd_wd_i;
   logic [NUM_RD-1:0]        rs_re_i;
   logic [NUM_RD*ADDR_W-1:0] rs_ra_i;
   logic [NUM_RD*DATA_W-1:0] rs_rd_o;
   logic                     init_done_o;
   logic                     iss_we_i;
   logic [ADDR_W-1:0]        iss_wa_i;
   logic [NUM_RD-1:0]        rs_busy_o;

   int n_checks = 0;
   int n_errors = 0;
   int cyc;

   gpr_file_mp #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .NUM_RD (NUM_RD),
      .NUM_WR (NUM_WR)
   ) u_dut (
      .clk_i       (clk_i),
      .n_rst_i     (n_rst_i),
      .rd_we_i     (rd_we_i),
      .rd_wa_i     (rd_wa_i),
      .rd_wd_i     (rd_wd_i),
      .rs_re_i     (rs_re_i),
      .rs_ra_i     (rs_ra_i),
      .rs_rd_o     (rs_rd_o),
      .init_done_o (init_done_o),
      .iss_we_i    (iss_we_i),
      .iss_wa_i    (iss_wa_i),
      .rs_busy_o   (rs_busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic wr(input int k, input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      rd_we_i[k]                 = we;
      rd_wa_i[k*ADDR_W +: ADDR_W] = a;
      rd_wd_i[k*DATA_W +: DATA_W] = d;
   endtask

   task automatic rd(input int j, input logic re, input logic [ADDR_W-1:0] a);
      rs_re_i[j]                 = re;
      rs_ra_i[j*ADDR_W +: ADDR_W] = a;
   endtask

   task automatic idle();
      rd_we_i  = '0;
      rd_wa_i  = '0;
      rd_wd_i  = '0;
      rs_re_i  = '0;
      rs_ra_i  = '0;
      iss_we_i = 1'b0;
      iss_wa_i = '0;
   endtask

   // Advance to just after the next rising edge, then inputs may be driven.
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic wait_init(output int n);
      n = 0;
      while (!init_done_o && n < 100) begin
         step();
         n++;
      end
   endtask

   initial begin
      n_rst_i = 1'b0;
      idle();
      step();
      step();

      // Reset state
      rd(0, 1'b1, 5'd7);
      @(negedge clk_i);
      check("rst_init_done", {31'd0, init_done_o}, 32'd0);
      check("rst_rd0", rs_rd_o[31:0], 32'd0);
      check("rst_busy", {30'd0, rs_busy_o}, 32'd0);

      // Release; a write to x7 is held throughout INIT and must be ignored
      step();
      wr(0, 1'b1, 5'd7, 32'hFFFF_FFFF);
      n_rst_i = 1'b1;
      step();
      @(negedge clk_i);
      check("init_rd_zero", rs_rd_o[31:0], 32'd0);
      check("init_not_done", {31'd0, init_done_o}, 32'd0);
      wait_init(cyc);
      check("init_cycles", cyc, 32'd30);
      idle();
      rd(0, 1'b1, 5'd7);
      @(negedge clk_i);
      check("x7_after_init", rs_rd_o[31:0], 32'd0);

      // Plain write then read on both ports
      step();
      idle();
      wr(0, 1'b1, 5'd5, 32'hDEAD_BEEF);
      step();
      idle();
      rd(0, 1'b1, 5'd5);
      rd(1, 1'b1, 5'd5);
      @(negedge clk_i);
      check("x5_port0", rs_rd_o[31:0], 32'hDEAD_BEEF);
      check("x5_port1", rs_rd_o[63:32], 32'hDEAD_BEEF);

      // Writes to x0 are discarded, no bypass for x0
      step();
      idle();
      wr(0, 1'b1, 5'd0, 32'h0000_1234);
      rd(0, 1'b1, 5'd0);
      @(negedge clk_i);
      check("x0_bypass", rs_rd_o[31:0], 32'd0);
      step();
      idle();
      rd(0, 1'b1, 5'd0);
      @(negedge clk_i);
      check("x0_read", rs_rd_o[31:0], 32'd0);

      // Write-through bypass; disabled port reads 0
      step();
      idle();
      wr(0, 1'b1, 5'd9, 32'hA5A5_A5A5);
      rd(0, 1'b1, 5'd9);
      rd(1, 1'b0, 5'd9);
      @(negedge clk_i);
      check("x9_bypass", rs_rd_o[31:0], 32'hA5A5_A5A5);
      check("x9_re0", rs_rd_o[63:32], 32'd0);
      step();
      idle();
      rd(1, 1'b1, 5'd9);
      @(negedge clk_i);
      check("x9_stored", rs_rd_o[63:32], 32'hA5A5_A5A5);

      // Same-address write conflict: port 1 wins
      step();
      idle();
      wr(0, 1'b1, 5'd3, 32'h0000_0011);
      wr(1, 1'b1, 5'd3, 32'h0000_0022);
      rd(0, 1'b1, 5'd3);
      @(negedge clk_i);
      check("x3_bypass_prio", rs_rd_o[31:0], 32'h0000_0022);
      step();
      idle();
      rd(0, 1'b1, 5'd3);
      rd(1, 1'b1, 5'd3);
      @(negedge clk_i);
      check("x3_stored_p0", rs_rd_o[31:0], 32'h0000_0022);
      check("x3_stored_p1", rs_rd_o[63:32], 32'h0000_0022);

      // Two ports writing different registers
      step();
      idle();
      wr(0, 1'b1, 5'd10, 32'h0000_00AA);
      wr(1, 1'b1, 5'd31, 32'h0000_00BB);
      step();
      idle();
      rd(0, 1'b1, 5'd10);
      rd(1, 1'b1, 5'd31);
      @(negedge clk_i);
      check("x10_stored", rs_rd_o[31:0], 32'h0000_00AA);
      check("x31_stored", rs_rd_o[63:32], 32'h0000_00BB);

      // Scoreboard
      step();
      idle();
      iss_we_i = 1'b1;
      iss_wa_i = 5'd4;
      step();
      idle();
      rd(0, 1'b1, 5'd4);
      rd(1, 1'b0, 5'd4);
      @(negedge clk_i);
`ifdef GPR_SCOREBOARD_EN
      check("busy_after_issue", {30'd0, rs_busy_o}, 32'd1);
`else
      check("busy_tied_off", {30'd0, rs_busy_o}, 32'd0);
`endif
      step();
      idle();
      wr(0, 1'b1, 5'd4, 32'h0000_0044);
      rd(0, 1'b1, 5'd4);
      @(negedge clk_i);
      check("busy_wb_bypass", {30'd0, rs_busy_o}, 32'd0);
      check("x4_bypass", rs_rd_o[31:0], 32'h0000_0044);
      step();
      idle();
      rd(0, 1'b1, 5'd4);
      @(negedge clk_i);
      check("busy_after_wb", {30'd0, rs_busy_o}, 32'd0);
      step();
      idle();
      iss_we_i = 1'b1;
      iss_wa_i = 5'd4;
      wr(1, 1'b1, 5'd4, 32'h0000_0045);
      step();
      idle();
      rd(0, 1'b1, 5'd4);
      rd(1, 1'b1, 5'd4);
      @(negedge clk_i);
`ifdef GPR_SCOREBOARD_EN
      check("busy_set_wins", {30'd0, rs_busy_o}, 32'd3);
`else
      check("busy_set_tied", {30'd0, rs_busy_o}, 32'd0);
`endif
      check("x4_stored", rs_rd_o[31:0], 32'h0000_0045);

      // Reset: reads forced to 0 asynchronously, then abort the sweep mid-INIT
      step();
      idle();
      rd(0, 1'b1, 5'd5);
      n_rst_i = 1'b0;
      #1;
      check("async_rst_rd", rs_rd_o[31:0], 32'd0);
      check("async_rst_done", {31'd0, init_done_o}, 32'd0);
      step();
      n_rst_i = 1'b1;
      for (int i = 0; i < 9; i++) step();
      n_rst_i = 1'b0;
      step();
      n_rst_i = 1'b1;
      wait_init(cyc);
      check("reinit_cycles", cyc, 32'd31);
      idle();
      rd(0, 1'b1, 5'd5);
      rd(1, 1'b1, 5'd31);
      @(negedge clk_i);
      check("x5_cleared", rs_rd_o[31:0], 32'd0);
      check("x31_cleared", rs_rd_o[63:32], 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
